// File: rtl/counter_jk_bist.sv
// Run controller and self-checker for the 3-bit JK up-counter (binary/Gray).
// Holds the counter in reset when idle, runs it for a latched length and scores every count.
module counter_jk_bist (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mode_sel,
  input  logic [3:0] run_len,
  input  logic [2:0] ctr_count,
  output logic       ctr_reset,
  output logic       ctr_mode,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] snap,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, CHECK} state_e;

  state_e     state_q, state_d;
  logic       mode_q, mode_d;
  logic [3:0] len_q, len_d;
  logic [3:0] k_q, k_d;
  logic [3:0] err_q, err_d;
  logic [2:0] exp_q, exp_d;
  logic [2:0] snap_q, snap_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic [3:0] eff_len;
  logic       mismatch;
  logic [3:0] err_upd;

  // Reference sequence the counter is expected to follow in each mode.
  function automatic logic [2:0] ref_next(input logic [2:0] c, input logic gray);
    logic [2:0] n;
    if (!gray) begin
      n = c + 3'd1;
    end else begin
      unique case (c)
        3'd0:    n = 3'd1;
        3'd1:    n = 3'd3;
        3'd3:    n = 3'd2;
        3'd2:    n = 3'd6;
        3'd6:    n = 3'd7;
        3'd7:    n = 3'd5;
        3'd5:    n = 3'd4;
        default: n = 3'd0;
      endcase
    end
    return n;
  endfunction

  // Out-of-range lengths (0, 9..15) fall back to a full 8-step run.
  assign eff_len  = (run_len == 4'd0 || run_len > 4'd8) ? 4'd8 : run_len;
  assign mismatch = (ctr_count != exp_q);
  assign err_upd  = (mismatch && err_q != 4'hF) ? err_q + 4'd1 : err_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    k_d     = k_q;
    err_d   = err_q;
    exp_d   = exp_q;
    snap_d  = snap_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_sel;
          len_d   = eff_len;
          err_d   = 4'd0;
          pass_d  = 1'b0;
          exp_d   = 3'd0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        k_d     = 4'd0;
        state_d = RUN;
      end
      RUN: begin
        err_d = err_upd;
        exp_d = ref_next(exp_q, mode_q);
        k_d   = k_q + 4'd1;
        if (k_q == len_q - 4'd1) state_d = CHECK;
      end
      CHECK: begin
        err_d   = err_upd;
        snap_d  = ctr_count;
        pass_d  = (err_upd == 4'd0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      len_q   <= 4'd0;
      k_q     <= 4'd0;
      err_q   <= 4'd0;
      exp_q   <= 3'd0;
      snap_q  <= 3'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      k_q     <= k_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      snap_q  <= snap_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Counter runs free only in RUN; CHECK clears it at its closing edge.
  assign ctr_reset = (state_q != RUN);
  assign busy      = (state_q != IDLE);
  assign ctr_mode  = mode_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign snap      = snap_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_counter_jk_bist.sv
// Bench for counter_jk_bist: behavioural JK counter with fault injection plus an
// arithmetic reference of the expected count sequence and run results.
module tb_counter_jk_bist;

  logic       clk = 1'b0;
  logic       reset, start, mode_sel;
  logic [3:0] run_len;
  logic [2:0] ctr_count;
  logic       ctr_reset, ctr_mode, busy, done, pass;
  logic [2:0] snap;
  logic [3:0] err_cnt;

  logic [2:0] cnt = 3'd0;
  logic [2:0] fmask = 3'd0;
  logic       force0 = 1'b0;

  int nassert = 0;
  int nfail   = 0;

  counter_jk_bist dut (
    .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel), .run_len(run_len),
    .ctr_count(ctr_count), .ctr_reset(ctr_reset), .ctr_mode(ctr_mode), .busy(busy),
    .done(done), .pass(pass), .snap(snap), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Gray counter steps via its binary index: decode, increment, re-encode.
  function automatic logic [2:0] gray_step(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[1] ^ b[2];
    b[0] = g[0] ^ b[1];
    b = b + 3'd1;
    return b ^ (b >> 1);
  endfunction

  always @(posedge clk) begin
    if (ctr_reset) cnt <= 3'd0;
    else           cnt <= ctr_mode ? gray_step(cnt) : cnt + 3'd1;
  end

  assign ctr_count = (force0 ? {cnt[2:1], 1'b0} : cnt) ^ fmask;

  // Expected counter value after i advances from 0.
  function automatic logic [2:0] ideal(input int i, input bit gray);
    int j;
    j = i % 8;
    if (gray) return 3'(j ^ (j >> 1));
    return 3'(j);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nassert++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_done"}, 8'(done), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_ctr_reset"}, 8'(ctr_reset), 8'd1);
  endtask

  // One complete run from the acceptance edge to the done cycle; returns in the done cycle.
  task automatic run(input bit gray, input logic [3:0] rl, input bit hold, input bit poke,
                     input bit f0, input int pct);
    int L, errs;
    logic [2:0] mask [9];
    logic [2:0] obs, last;
    L = (rl == 4'd0 || rl > 4'd8) ? 8 : int'(rl);
    errs = 0;
    last = 3'd0;
    for (int i = 0; i < 9; i++)
      mask[i] = ($urandom_range(0, 99) < pct) ? 3'($urandom_range(1, 7)) : 3'd0;
    for (int i = 0; i <= L; i++) begin
      obs = (f0 ? (ideal(i, gray) & 3'b110) : ideal(i, gray)) ^ mask[i];
      if (obs != ideal(i, gray)) errs++;
      if (i == L) last = obs;
    end
    if (errs > 15) errs = 15;

    force0 = f0; mode_sel = gray; run_len = rl; start = 1'b1;
    tick;
    if (!hold) start = 1'b0;
    chk("clear_busy", 8'(busy), 8'd1);
    chk("clear_ctr_reset", 8'(ctr_reset), 8'd1);
    chk("mode_latched", 8'(ctr_mode), 8'(gray));
    chk("clear_done", 8'(done), 8'd0);
    chk("clear_err", 8'(err_cnt), 8'd0);
    chk("clear_pass", 8'(pass), 8'd0);
    for (int i = 0; i <= L; i++) begin
      tick;
      fmask = mask[i];
      chk("run_ctr_reset", 8'(ctr_reset), 8'(i == L));
      chk("run_busy", 8'(busy), 8'd1);
      chk("run_done", 8'(done), 8'd0);
      chk("run_mode", 8'(ctr_mode), 8'(gray));
      if (poke && L >= 2) begin
        if (i == 1) begin start = 1'b1; mode_sel = !gray; run_len = rl + 4'd3; end
        if (i == 2) start = hold;
      end
    end
    tick;
    fmask = 3'd0; force0 = 1'b0;
    chk("end_done", 8'(done), 8'd1);
    chk("end_busy", 8'(busy), 8'd0);
    chk("end_ctr_reset", 8'(ctr_reset), 8'd1);
    chk("end_snap", 8'(snap), 8'(last));
    chk("end_err", 8'(err_cnt), 8'(errs));
    chk("end_pass", 8'(pass), 8'(errs == 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; start = 1'b0; mode_sel = 1'b0; run_len = 4'd0;
    #2;
    chk_idle("rst");
    chk("rst_mode", 8'(ctr_mode), 8'd0);
    chk("rst_pass", 8'(pass), 8'd0);
    chk("rst_snap", 8'(snap), 8'd0);
    chk("rst_err", 8'(err_cnt), 8'd0);
    tick; tick;
    reset = 1'b1;
    tick;
    chk_idle("post_rst");

    // Binary 5, Gray 8, run_len 0 treated as 8, stuck-at-0 bit 0 with length 3.
    run(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 0);  tick; chk_idle("after_bin5");
    run(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 0);  tick; chk_idle("after_gray8");
    run(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 0);  tick; chk_idle("after_len0");
    run(1'b0, 4'd3, 1'b0, 1'b0, 1'b1, 0);  tick; chk_idle("after_stuck");
    chk("stuck_err_held", 8'(err_cnt), 8'd2);

    // Start pulse and mode toggle mid-run, then back-to-back runs with start held.
    run(1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 0);  tick; chk_idle("after_poke");
    run(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 0);
    run(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 0);  tick; chk_idle("after_b2b");

    // Asynchronous reset in the third RUN cycle of a Gray run.
    run(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 0);  tick;
    mode_sel = 1'b1; run_len = 4'd5; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("pre_rst_busy", 8'(busy), 8'd1);
    #2 reset = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_mode", 8'(ctr_mode), 8'd0);
    chk("mid_rst_pass", 8'(pass), 8'd0);
    chk("mid_rst_snap", 8'(snap), 8'd0);
    chk("mid_rst_err", 8'(err_cnt), 8'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_idle("post_mid_rst");
    end
    run(1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 0);  tick; chk_idle("after_rst_run");

    // Random modes, lengths (incl. out of range), injected faults and mid-run pokes.
    for (int r = 0; r < 10; r++) begin
      run(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30);
      tick;
      chk_idle("rand_idle");
      repeat ($urandom_range(0, 2)) tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule

// File: doc/counter_jk_bist.md
# counter_jk_bist

Controller and self-checker for the 3-bit JK up-counter (binary mode / Gray mode). It holds the counter in synchronous reset while idle. On a start request it clears the counter, releases it for a programmed number of clock cycles, and compares every observed count against an internal reference model. It reports the final count, a mismatch count and a pass flag. It sits beside the counter in the sequential lab top and drives the counter's `reset` and `mode` inputs.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  rising-edge clock, shared with the counter
- `reset`  in  1  asynchronous, active-low; forces state IDLE and all registers to reset values
- `start`  in  1  run request; sampled only in IDLE
- `mode_sel`  in  1  0 = binary up (0,1,2..7,0), 1 = Gray (0,1,3,2,6,7,5,4,0)
- `run_len`  in  4  number of counter advances, 1..8; values 0 and 9..15 are treated as 8
- `ctr_count`  in  3  count output of the counter under control
- `ctr_reset`  out  1  synchronous active-high reset to the counter; combinational from state
- `ctr_mode`  out  1  mode to the counter; registered
- `busy`  out  1  high whenever state is not IDLE; combinational
- `done`  out  1  one-cycle registered pulse at the end of a run
- `pass`  out  1  result of the last run; registered; held until the next start is accepted
- `snap`  out  3  final count of the last run; registered
- `err_cnt`  out  4  mismatches in the last run; saturates at 15

## Operation
- States: IDLE, CLEAR, RUN, CHECK.
- IDLE
  - `ctr_reset`=1.
  - If `start`=1: latch `mode_sel` into `ctr_mode`, latch the effective run length into `len`, clear `err_cnt`, `pass` and `exp` (expected count) to 0, then go to CLEAR.
- CLEAR
  - One cycle. `ctr_reset`=1 so the counter loads 0 under the new mode.
  - Clear the step counter `k` to 0. Go to RUN.
- RUN
  - `ctr_reset`=0.
  - Each cycle: compare `ctr_count` with `exp`; on mismatch, increment `err_cnt` (saturating).
  - Then `exp` <= next(`exp`, `ctr_mode`) and `k` <= `k`+1.
  - When `k` = `len`-1, go to CHECK. RUN therefore lasts exactly `len` cycles.
- CHECK
  - One cycle. `ctr_reset`=1; the counter clears at the end of this cycle.
  - Compare `ctr_count` with `exp`, which equals step `len` and wraps to 0 when `len`=8.
  - At the closing edge:
    - `snap` <= `ctr_count`
    - `err_cnt` updated with this comparison
    - `pass` <= 1 iff the updated `err_cnt` = 0
    - `done` <= 1
    - go to IDLE.
- Total comparisons per run: `len`+1.
- Reference next-state function:
  - Binary: `exp`+1 mod 8.
  - Gray: 0→1→3→2→6→7→5→4→0.
- `start` while `busy`=1 is ignored; there is no queueing.
- `start` held high continuously: the next run is accepted in the first IDLE cycle, i.e. the same cycle `done` is high.
- `mode_sel` and `run_len` changes mid-run have no effect; both are latched at acceptance.
- Reset values:
  - state IDLE, `ctr_reset`=1, `busy`=0
  - `ctr_mode`=0, `done`=0, `pass`=0, `snap`=0, `err_cnt`=0
  - `exp`, `k`, `len` all 0

## Timing
- `start` sampled at edge E0 → CLEAR during E0..E1 → RUN for `len` cycles → CHECK → `done`=1 in the cycle after edge E(`len`+2).
- Latency from start to done is `len`+2 cycles; `busy` is high for `len`+2 cycles.
- `done` is high for exactly one cycle. `snap`, `err_cnt` and `pass` are valid from that cycle until the next accepted start.
- `ctr_mode` changes only at the acceptance edge, while the counter is held in reset.
- Asynchronous reset assertion mid-run:
  - Immediately forces `ctr_reset`=1 and `busy`=0, with no `done` pulse.
  - After release, the block sits in IDLE.
- Counter reset is synchronous, so `ctr_count` reads 0 in the first RUN cycle. Any other value is counted as a mismatch.

## Test plan
- Binary run, `mode_sel`=0, `run_len`=5:
  - `ctr_count` seen 0,1,2,3,4,5.
  - `done` 7 cycles after the start edge; `snap`=5, `err_cnt`=0, `pass`=1.
- Gray run, `mode_sel`=1, `run_len`=8:
  - Observed sequence 0,1,3,2,6,7,5,4,0.
  - `snap`=0, `err_cnt`=0, `pass`=1; `busy` high 10 cycles.
- `run_len`=0 in binary mode:
  - Behaves as 8; `snap`=0 (wrapped), `pass`=1, `done` 10 cycles after start.
- Faulty counter: bench forces `ctr_count[0]`=0, binary, `run_len`=3:
  - Observed 0,0,2,2 against expected 0,1,2,3.
  - `err_cnt`=2, `snap`=2, `pass`=0.
- `start` pulsed again during RUN, and `mode_sel` toggled mid-run:
  - No effect; a single `done` pulse and unchanged results.
  - A back-to-back start with `start` held high begins the next run in the `done` cycle.
- `reset` driven low during the 3rd RUN cycle:
  - `ctr_reset`=1 and `busy`=0 immediately; all outputs take reset values; no `done` pulse.
  - A subsequent run with `run_len`=2 passes with `snap`=2.
